// File: rtl/mem_writeback_buffer_if.sv
// Load-return / writeback-mux signal bundle for one mem_writeback_buffer instance.
// master = environment side (memory port + mux), slave = the buffer itself.
interface mem_writeback_buffer_if #(
  parameter int DATABITWIDTH    = 16,
  parameter int REGADDRBITWIDTH = 4,
  parameter int DEPTHADDRWIDTH  = 2
);
  logic                       LoadRespValid;
  logic                       LoadRespReady;
  logic [DATABITWIDTH-1:0]    LoadRespData;
  logic [REGADDRBITWIDTH-1:0] LoadRespAddr;
  logic                       MemWritebackACK;
  logic                       MemWritebackREQ;
  logic [DATABITWIDTH-1:0]    MemWritebackDataOut;
  logic [REGADDRBITWIDTH-1:0] MemWritebackAddrOut;
  logic [DEPTHADDRWIDTH:0]    Occupancy;

  modport master (
    output LoadRespValid, LoadRespData, LoadRespAddr, MemWritebackREQ,
    input  LoadRespReady, MemWritebackACK, MemWritebackDataOut, MemWritebackAddrOut, Occupancy
  );

  modport slave (
    input  LoadRespValid, LoadRespData, LoadRespAddr, MemWritebackREQ,
    output LoadRespReady, MemWritebackACK, MemWritebackDataOut, MemWritebackAddrOut, Occupancy
  );
endinterface

// File: rtl/mem_writeback_buffer.sv
// Per-port FIFO of load results feeding the memory writeback mux.
// Latency 1 cycle push->ACK; 0 cycles when MEM_WB_BUFFER_BYPASS_EN is defined and empty.
// Backpressure: Ready drops when full (state-only); mux pops head on REQ while ACK is high.
module mem_writeback_buffer #(
  parameter int DATABITWIDTH    = 16,
  parameter int REGADDRBITWIDTH = 4,
  parameter int DEPTH           = 4,
  parameter int DEPTHADDRWIDTH  = 2
) (
  input logic clk,
  input logic clk_en,
  input logic sync_rst,
  mem_writeback_buffer_if.slave wbIf
);

  localparam logic [DEPTHADDRWIDTH:0] FULLCOUNT = (DEPTHADDRWIDTH+1)'(DEPTH);

  logic [DATABITWIDTH-1:0]    dataMem [DEPTH];
  logic [REGADDRBITWIDTH-1:0] addrMem [DEPTH];
  logic [DEPTHADDRWIDTH-1:0]  wrPtr;
  logic [DEPTHADDRWIDTH-1:0]  rdPtr;
  logic [DEPTHADDRWIDTH:0]    count;
  logic                       notEmpty;
  logic                       push;
  logic                       pop;

  assign notEmpty           = (count != '0);
  assign wbIf.LoadRespReady = (count != FULLCOUNT) & sync_rst;
  assign wbIf.Occupancy     = count;
  assign pop                = notEmpty & wbIf.MemWritebackREQ & clk_en;

`ifdef MEM_WB_BUFFER_BYPASS_EN
  logic bypass;
  // An empty buffer forwards the incoming result straight to the mux; a granted
  // forward never touches storage.
  assign bypass               = ~notEmpty & wbIf.LoadRespValid & sync_rst;
  assign wbIf.MemWritebackACK = notEmpty | bypass;
  assign wbIf.MemWritebackDataOut = notEmpty ? dataMem[rdPtr] :
                                    (bypass ? wbIf.LoadRespData : '0);
  assign wbIf.MemWritebackAddrOut = notEmpty ? addrMem[rdPtr] :
                                    (bypass ? wbIf.LoadRespAddr : '0);
  assign push = wbIf.LoadRespValid & wbIf.LoadRespReady & clk_en
              & ~(bypass & wbIf.MemWritebackREQ);
`else
  assign wbIf.MemWritebackACK     = notEmpty;
  assign wbIf.MemWritebackDataOut = notEmpty ? dataMem[rdPtr] : '0;
  assign wbIf.MemWritebackAddrOut = notEmpty ? addrMem[rdPtr] : '0;
  assign push = wbIf.LoadRespValid & wbIf.LoadRespReady & clk_en;
`endif

  always_ff @(posedge clk) begin
    if (clk_en) begin
      if (!sync_rst) begin
        wrPtr <= '0;
        rdPtr <= '0;
        count <= '0;
      end else begin
        if (push) wrPtr <= wrPtr + 1'b1;
        if (pop)  rdPtr <= rdPtr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // Storage is deliberately left uncleared by reset; count gates what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      dataMem[wrPtr] <= wbIf.LoadRespData;
      addrMem[wrPtr] <= wbIf.LoadRespAddr;
    end
  end

endmodule

// File: tb/tb_mem_writeback_buffer.sv
// Directed bench for mem_writeback_buffer: stimulus queues expected results,
// a negedge monitor pops and compares each granted writeback.
module tb_mem_writeback_buffer;

  logic clk = 1'b0;
  logic clk_en;
  logic sync_rst;
  int   checks = 0;
  int   errors = 0;
  int   popCnt = 0;
  logic [19:0] expQ [$];

  mem_writeback_buffer_if #(.DATABITWIDTH(16), .REGADDRBITWIDTH(4), .DEPTHADDRWIDTH(2)) wbIf ();

  mem_writeback_buffer #(
    .DATABITWIDTH(16), .REGADDRBITWIDTH(4), .DEPTH(4), .DEPTHADDRWIDTH(2)
  ) dut (
    .clk(clk), .clk_en(clk_en), .sync_rst(sync_rst), .wbIf(wbIf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic [3:0] a, input logic r);
    wbIf.LoadRespValid   = v;
    wbIf.LoadRespData    = d;
    wbIf.LoadRespAddr    = a;
    wbIf.MemWritebackREQ = r;
  endtask

  // Stimulus side records results it expects the buffer to accept.
  task automatic expect_push(input logic [15:0] d, input logic [3:0] a);
    expQ.push_back({a, d});
  endtask

  // Monitor: every granted writeback must match the oldest expected result.
  always @(negedge clk) begin
    if (clk_en && sync_rst && wbIf.MemWritebackACK && wbIf.MemWritebackREQ) begin
      popCnt++;
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_unexpected: got 0x%0h/r%0d expected no writeback",
                 wbIf.MemWritebackDataOut, wbIf.MemWritebackAddrOut);
      end else begin
        logic [19:0] e;
        e = expQ.pop_front();
        chk("wb_data", {16'h0, wbIf.MemWritebackDataOut}, {16'h0, e[15:0]});
        chk("wb_addr", {28'h0, wbIf.MemWritebackAddrOut}, {28'h0, e[19:16]});
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clk_en   = 1'b1;
    sync_rst = 1'b0;
    drive(1'b0, 16'h0, 4'h0, 1'b0);

    // Reset
    cyc(); cyc();
    chk("rst_ack",   {31'h0, wbIf.MemWritebackACK}, 32'd0);
    chk("rst_ready", {31'h0, wbIf.LoadRespReady},   32'd0);
    chk("rst_occ",   {29'h0, wbIf.Occupancy},       32'd0);
    sync_rst = 1'b1;
    cyc();
    chk("rel_ready", {31'h0, wbIf.LoadRespReady}, 32'd1);

    // Fill and drain
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 16'hA000 + 16'(i), 4'(i), 1'b0);
      expect_push(16'hA000 + 16'(i), 4'(i));
      cyc();
    end
    chk("full_occ",   {29'h0, wbIf.Occupancy},     32'd4);
    chk("full_ready", {31'h0, wbIf.LoadRespReady}, 32'd0);
    drive(1'b1, 16'hA005, 4'd5, 1'b0);
    cyc();
    chk("full_hold_occ", {29'h0, wbIf.Occupancy},           32'd4);
    chk("full_head",     {16'h0, wbIf.MemWritebackDataOut}, 32'hA001);
    drive(1'b0, 16'h0, 4'h0, 1'b1);
    repeat (4) cyc();
    chk("drain_ack",  {31'h0, wbIf.MemWritebackACK},     32'd0);
    chk("drain_occ",  {29'h0, wbIf.Occupancy},           32'd0);
    chk("drain_data", {16'h0, wbIf.MemWritebackDataOut}, 32'd0);

    // Concurrent push/pop at count==1, then across the pointer wrap
    drive(1'b1, 16'hC001, 4'd3, 1'b0);
    expect_push(16'hC001, 4'd3);
    cyc();
    drive(1'b1, 16'hBEEF, 4'd7, 1'b1);
    expect_push(16'hBEEF, 4'd7);
    cyc();
    chk("pp_occ",  {29'h0, wbIf.Occupancy},           32'd1);
    chk("pp_data", {16'h0, wbIf.MemWritebackDataOut}, 32'hBEEF);
    chk("pp_addr", {28'h0, wbIf.MemWritebackAddrOut}, 32'd7);
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 16'hD000 + 16'(i), 4'(i), 1'b1);
      expect_push(16'hD000 + 16'(i), 4'(i));
      cyc();
    end
    chk("wrap_occ",  {29'h0, wbIf.Occupancy},           32'd1);
    chk("wrap_head", {16'h0, wbIf.MemWritebackDataOut}, 32'hD00A);
    drive(1'b0, 16'h0, 4'h0, 1'b1);
    cyc();
    chk("wrap_empty", {29'h0, wbIf.Occupancy}, 32'd0);

    // Clock enable low freezes everything
    drive(1'b1, 16'hE001, 4'd1, 1'b0); expect_push(16'hE001, 4'd1); cyc();
    drive(1'b1, 16'hE002, 4'd2, 1'b0); expect_push(16'hE002, 4'd2); cyc();
    clk_en = 1'b0;
    drive(1'b1, 16'hE0FF, 4'd15, 1'b1);
    repeat (3) cyc();
    chk("cen_occ",  {29'h0, wbIf.Occupancy},           32'd2);
    chk("cen_head", {16'h0, wbIf.MemWritebackDataOut}, 32'hE001);
    chk("cen_ack",  {31'h0, wbIf.MemWritebackACK},     32'd1);
    clk_en = 1'b1;
    drive(1'b0, 16'h0, 4'h0, 1'b1);
    repeat (2) cyc();
    chk("cen_drain", {29'h0, wbIf.Occupancy}, 32'd0);

    // Reset mid-operation discards queued entries
    drive(1'b0, 16'h0, 4'h0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 16'hF000 + 16'(i), 4'(i), 1'b0);
      cyc();
    end
    drive(1'b0, 16'h0, 4'h0, 1'b0);
    chk("mid_occ3", {29'h0, wbIf.Occupancy}, 32'd3);
    sync_rst = 1'b0;
    cyc();
    chk("mid_ack", {31'h0, wbIf.MemWritebackACK}, 32'd0);
    chk("mid_occ", {29'h0, wbIf.Occupancy},       32'd0);
    sync_rst = 1'b1;
    drive(1'b0, 16'h0, 4'h0, 1'b1);
    repeat (2) cyc();
    chk("mid_stale_ack",  {31'h0, wbIf.MemWritebackACK},     32'd0);
    chk("mid_stale_data", {16'h0, wbIf.MemWritebackDataOut}, 32'd0);

    // Empty with REQ high: bypass forwards in-cycle, otherwise one cycle later
    drive(1'b1, 16'h1234, 4'd2, 1'b1);
    expect_push(16'h1234, 4'd2);
    #1;
`ifdef MEM_WB_BUFFER_BYPASS_EN
    chk("byp_ack",  {31'h0, wbIf.MemWritebackACK},     32'd1);
    chk("byp_data", {16'h0, wbIf.MemWritebackDataOut}, 32'h1234);
    cyc();
    drive(1'b0, 16'h0, 4'h0, 1'b0);
    chk("byp_occ", {29'h0, wbIf.Occupancy}, 32'd0);
`else
    chk("nobyp_ack0", {31'h0, wbIf.MemWritebackACK}, 32'd0);
    cyc();
    drive(1'b0, 16'h0, 4'h0, 1'b1);
    chk("nobyp_ack1", {31'h0, wbIf.MemWritebackACK},     32'd1);
    chk("nobyp_data", {16'h0, wbIf.MemWritebackDataOut}, 32'h1234);
    chk("nobyp_occ",  {29'h0, wbIf.Occupancy},           32'd1);
    cyc();
    drive(1'b0, 16'h0, 4'h0, 1'b0);
    chk("nobyp_occ0", {29'h0, wbIf.Occupancy}, 32'd0);
`endif
    cyc();

    chk("sb_leftover", 32'(expQ.size()), 32'd0);
    chk("sb_popcount", 32'(popCnt),      32'd19);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
